// File: rtl/regfile_dbg_access.sv
// -----------------------------------------------------------------------------
// regfile_dbg_access
//
// Debug-side initiator for the register-file port. Takes single-register
// read / write commands and a full-dump command on a valid/ready command
// channel and returns one response per register touched on a valid/ready
// response channel. While o_busy=1 the external mux hands the register-file
// port to this block.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_op                00 read, 01 write, 10 dump, 11 illegal
//   i_cmd_addr, i_cmd_wdata target register, write data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_data, o_rsp_addr  read value (or write read-back) and its register
//   o_rsp_last, o_rsp_err   final response of a command, illegal opcode
//   o_busy                  block owns the register-file port
//   o_rf_rs1, i_rf_readdata1  register-file read address / combinational data
//   o_rf_rd, o_rf_writedata, o_rf_regwrite  register-file write port
//
// All outputs come straight from flops. The next-state process computes the
// value every output register takes on the following edge.
// -----------------------------------------------------------------------------
module regfile_dbg_access #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_rsp_last,
    output logic              o_rsp_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rf_rs1,
    output logic [ADDR_W-1:0] o_rf_rd,
    output logic [DATA_W-1:0] o_rf_writedata,
    output logic              o_rf_regwrite,
    input  logic [DATA_W-1:0] i_rf_readdata1
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_VERIFY, S_DUMP, S_RSP
    } state_t;

    localparam logic [1:0]        OP_READ  = 2'b00;
    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_DUMP  = 2'b10;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t              r_state,    w_state_nxt;
    logic [1:0]          r_op,       w_op_nxt;
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
    logic [ADDR_W-1:0]   r_idx,      w_idx_nxt;
    logic                r_cmd_ready, w_cmd_ready_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic [ADDR_W-1:0]   r_rsp_addr, w_rsp_addr_nxt;
    logic                r_rsp_last, w_rsp_last_nxt;
    logic                r_rsp_err,  w_rsp_err_nxt;
    logic [ADDR_W-1:0]   r_rf_rs1,   w_rf_rs1_nxt;
    logic [ADDR_W-1:0]   r_rf_rd,    w_rf_rd_nxt;
    logic [DATA_W-1:0]   r_rf_wd,    w_rf_wd_nxt;
    logic                r_rf_we,    w_rf_we_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rf_rs1    <= '0;
            r_rf_rd     <= '0;
            r_rf_wd     <= '0;
            r_rf_we     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_idx       <= w_idx_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rf_rs1    <= w_rf_rs1_nxt;
            r_rf_rd     <= w_rf_rd_nxt;
            r_rf_wd     <= w_rf_wd_nxt;
            r_rf_we     <= w_rf_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_idx_nxt       = r_idx;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_last_nxt  = r_rsp_last;
        w_rsp_err_nxt   = r_rsp_err;
        // Register-file drives default to idle every cycle; only the state
        // being entered asserts them, so the write enable is a one-cycle pulse.
        w_rf_rs1_nxt    = '0;
        w_rf_rd_nxt     = '0;
        w_rf_wd_nxt     = '0;
        w_rf_we_nxt     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_op_nxt    = i_cmd_op;
                    w_addr_nxt  = i_cmd_addr;
                    w_wdata_nxt = i_cmd_wdata;
                    unique case (i_cmd_op)
                        OP_READ: begin
                            w_state_nxt  = S_READ;
                            w_rf_rs1_nxt = i_cmd_addr;
                        end
                        OP_WRITE: begin
                            w_state_nxt = S_WRITE;
                            w_rf_rd_nxt = i_cmd_addr;
                            w_rf_wd_nxt = i_cmd_wdata;
                            w_rf_we_nxt = 1'b1;
                        end
                        OP_DUMP: begin
                            w_state_nxt  = S_DUMP;
                            w_idx_nxt    = '0;
                            w_rf_rs1_nxt = '0;
                        end
                        default: begin
                            w_state_nxt     = S_RSP;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = '0;
                            w_rsp_addr_nxt  = i_cmd_addr;
                            w_rsp_last_nxt  = 1'b1;
                            w_rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                w_state_nxt  = S_VERIFY;
                w_rf_rs1_nxt = r_addr;
            end
            // READ and VERIFY both capture the value addressed by rf_rs1.
            S_READ, S_VERIFY: begin
                w_state_nxt     = S_RSP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = i_rf_readdata1;
                w_rsp_addr_nxt  = r_addr;
                w_rsp_last_nxt  = 1'b1;
                w_rsp_err_nxt   = 1'b0;
            end
            S_DUMP: begin
                w_state_nxt     = S_RSP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = i_rf_readdata1;
                w_rsp_addr_nxt  = r_idx;
                w_rsp_last_nxt  = (r_idx == LAST_IDX);
                w_rsp_err_nxt   = 1'b0;
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    // The last flag of the response just taken decides whether
                    // a dump continues; idx therefore stops at NREGS-1.
                    if (r_op == OP_DUMP && !r_rsp_last) begin
                        w_state_nxt  = S_DUMP;
                        w_idx_nxt    = r_idx + ADDR_W'(1);
                        w_rf_rs1_nxt = r_idx + ADDR_W'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_busy         = r_busy;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_addr     = r_rsp_addr;
    assign o_rsp_last     = r_rsp_last;
    assign o_rsp_err      = r_rsp_err;
    assign o_rf_rs1       = r_rf_rs1;
    assign o_rf_rd        = r_rf_rd;
    assign o_rf_writedata = r_rf_wd;
    assign o_rf_regwrite  = r_rf_we;

endmodule

// File: tb/tb_regfile_dbg_access.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_dbg_access. A behavioural register file (combinational
// read, x0 reads 0, write on rising edge) sits on the register-file port.
// Stimulus pushes the expected response into a queue; a monitor pops and
// compares on every response handshake. Latency is counted from the clock
// edge that opens the cycle in which the command is first presented.
// -----------------------------------------------------------------------------
module tb_regfile_dbg_access;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic              err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] rf_rs1;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    logic [DATA_W-1:0] rf_mem [NREGS] = '{default: '0};

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   we_cnt   = 0;
    logic [ADDR_W-1:0] last_rd = '0;

    regfile_dbg_access #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_addr     (cmd_addr),
        .i_cmd_wdata    (cmd_wdata),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_addr     (rsp_addr),
        .o_rsp_last     (rsp_last),
        .o_rsp_err      (rsp_err),
        .o_busy         (busy),
        .o_rf_rs1       (rf_rs1),
        .o_rf_rd        (rf_rd),
        .o_rf_writedata (rf_wd),
        .o_rf_regwrite  (rf_we),
        .i_rf_readdata1 (rf_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model
    assign rf_rdata = (rf_rs1 == '0) ? '0 : rf_mem[rf_rs1];
    always @(posedge clk) if (rf_we && rf_rd != '0) rf_mem[rf_rd] <= rf_wd;

    // Write-enable observer: cycles with regwrite high and the address used
    always @(negedge clk) begin
        if (rf_we) begin
            we_cnt  = we_cnt + 1;
            last_rd = rf_rd;
        end
    end

    // Response monitor / scoreboard
    always @(negedge clk) begin
        rsp_t got, e;
        if (rst_n && rsp_valid && rsp_ready) begin
            got = '{rsp_data, rsp_addr, rsp_last, rsp_err};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL rsp_unexpected actual data=%h addr=%0d last=%b err=%b required none",
                         got.data, got.addr, got.last, got.err);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures = failures + 1;
                    $display("FAIL rsp actual data=%h addr=%0d last=%b err=%b required data=%h addr=%0d last=%b err=%b",
                             got.data, got.addr, got.last, got.err, e.data, e.addr, e.last, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic void push(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                                 input logic l, input logic e);
        exp_q.push_back('{d, a, l, e});
    endfunction

    // Present one command once the block is idle; n = edge opening the cycle.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int n);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("issue_wait_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        n = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        bit ok = 0;
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; c = cyc; break; end
        end
        if (!ok) timeout("wait_rsp_valid");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, c, w0;
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_regwrite",  32'(rf_we),     32'd0);
        chk("rst_rf_rs1",    32'(rf_rs1),    32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Write x9 = 1, then read it back
        w0 = we_cnt;
        push(32'h1, 5'd9, 1'b1, 1'b0);
        issue(2'b01, 5'd9, 32'h1, n);
        wait_valid(c);
        chk("wr_latency", 32'(c - n), 32'd3);
        wait_idle();
        chk("wr_pulse_cycles", 32'(we_cnt - w0), 32'd1);
        chk("wr_rf_rd", 32'(last_rd), 32'd9);
        push(32'h1, 5'd9, 1'b1, 1'b0);
        issue(2'b00, 5'd9, 32'h0, n);
        wait_valid(c);
        chk("rd_latency", 32'(c - n), 32'd2);
        wait_idle();

        // x0 stays zero
        push(32'h0, 5'd0, 1'b1, 1'b0);
        issue(2'b01, 5'd0, 32'hDEADBEEF, n);
        wait_idle();
        push(32'h0, 5'd0, 1'b1, 1'b0);
        issue(2'b00, 5'd0, 32'h0, n);
        wait_idle();

        // Backpressure on a read, with a command offered while busy
        push(32'h3, 5'd3, 1'b1, 1'b0);
        issue(2'b01, 5'd3, 32'h3, n);
        wait_idle();
        push(32'h1, 5'd9, 1'b1, 1'b0);
        issue(2'b01, 5'd9, 32'h1, n);
        wait_idle();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        w0 = we_cnt;
        push(32'h3, 5'd3, 1'b1, 1'b0);
        issue(2'b00, 5'd3, 32'h0, n);
        wait_valid(c);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd5; cmd_wdata = 32'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data",  rsp_data,       32'h3);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("busy_cmd_no_write", 32'(we_cnt - w0), 32'd0);
        chk("busy_cmd_x5", rf_mem[5], 32'h0);

        // Illegal opcode
        w0 = we_cnt;
        push(32'h0, 5'd7, 1'b1, 1'b1);
        issue(2'b11, 5'd7, 32'h12345678, n);
        wait_idle();
        chk("illegal_no_write", 32'(we_cnt - w0), 32'd0);

        // Load x1..x31, then dump
        for (int i = 1; i < NREGS; i++) begin
            push(32'h100 + 32'(i), 5'(i), 1'b1, 1'b0);
            issue(2'b01, 5'(i), 32'h100 + 32'(i), n);
            wait_idle();
        end
        for (int i = 0; i < NREGS; i++)
            push((i == 0) ? 32'h0 : 32'h100 + 32'(i), 5'(i), (i == NREGS - 1), 1'b0);
        issue(2'b10, 5'd13, 32'h0, n);
        ok = 0; c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_last) begin ok = 1; c = cyc; break; end
        end
        if (!ok) timeout("dump_last");
        chk("dump_span", 32'(c - n), 32'd64);
        @(negedge clk);
        chk("dump_busy_low",  32'(busy),      32'd0);
        chk("dump_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("dump_all_rsp",   32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write
        wait_idle();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd12; cmd_wdata = 32'h0000ABCD;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstwr_we_before", 32'(rf_we), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rstwr_we_async", 32'(rf_we), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwr_x12_kept",  rf_mem[12],      32'h10C);
        chk("rstwr_cmd_ready", 32'(cmd_ready),  32'd1);
        chk("rstwr_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rstwr_busy",      32'(busy),       32'd0);
        chk("sb_empty",        32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dbg_access.md
Name: regfile_dbg_access

Overview:
- Debug-side initiator for the register file port. Drives read-address, write-address, write-data and write-enable, and consumes read data.
- Accepts single-register read/write commands and a full-dump command over a valid/ready command channel. Returns results over a valid/ready response channel.
- Sits between the debug interface and the register file. Register-file port muxing against the core is external; the mux selects this block while busy=1.

Parameters:
NREGS, 32, number of architectural registers walked by a dump
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 read, 01 write, 10 dump, 11 illegal
cmd_addr  in  ADDR_W  target register (ignored for dump)
cmd_wdata  in  DATA_W  write data (write only)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  read value / write read-back value
rsp_addr  out  ADDR_W  register the response refers to
rsp_last  out  1  final response of a command
rsp_err  out  1  illegal opcode
busy  out  1  block owns the register-file port (state != IDLE)
rf_rs1  out  ADDR_W  register-file read address
rf_rd  out  ADDR_W  register-file write address
rf_writedata  out  DATA_W  register-file write data
rf_regwrite  out  1  register-file write enable
rf_readdata1  in  DATA_W  combinational read data for rf_rs1

Behaviour:
- Register file contract: combinational read; write on the rising edge when rf_regwrite=1; x0 always reads 0.
- All outputs are registered.
- Reset (async, any state): state=IDLE; cmd_ready=1; every other output=0. rf_regwrite drops immediately, so no partial or spurious write. Dump counter clears.
- FSM states: IDLE, READ, WRITE, VERIFY, DUMP, RSP.
- IDLE: cmd_ready=1. A handshake (cmd_valid&cmd_ready) latches op/addr/wdata; cmd_ready=0 from the next cycle.
  - op 00 -> READ
  - op 01 -> WRITE
  - op 10 -> DUMP with idx=0
  - op 11 -> RSP with rsp_err=1, rsp_data=0, rsp_addr=cmd_addr, rsp_last=1
- READ (1 cycle): rf_rs1=addr. At end of cycle capture rf_readdata1 into rsp_data -> RSP with rsp_last=1.
- WRITE (1 cycle): rf_rd=addr, rf_writedata=wdata, rf_regwrite=1 for exactly this cycle -> VERIFY.
- VERIFY (1 cycle): rf_regwrite=0, rf_rs1=addr; capture rf_readdata1 (the read-back) -> RSP with rsp_last=1. A write to x0 returns 0.
- DUMP: rf_rs1=idx; capture rf_readdata1, rsp_addr=idx, rsp_last=(idx==NREGS-1) -> RSP.
- RSP: rsp_valid=1. rsp_data/addr/last/err are held stable until rsp_ready. On handshake rsp_valid drops next cycle, then:
  - if dump and !last: idx++ and go to DUMP
  - otherwise go to IDLE
- Latency:
  - Read: accept edge N; rsp_valid=1 from edge N+2.
  - Write: rf_regwrite high cycle N+1..N+2; rsp_valid from edge N+3.
  - Dump with rsp_ready tied 1: one response every 2 cycles, 32 responses, 64 cycles total.
- Back-to-back: a new command is accepted at the earliest one cycle after the final response handshake (IDLE re-entered).
- cmd_valid held while busy: ignored, no side effect.
- Dump idx never wraps; it stops at NREGS-1.
- rf_rs1 and rf_rd are 0 when their use is inactive.
- rf_regwrite is never 1 outside WRITE.

Test Plan:
- Write x9=0x00000001 -> rf_regwrite high exactly 1 cycle with rf_rd=9; response rsp_data=0x1, rsp_addr=9, rsp_last=1, rsp_err=0; a subsequent read of x9 returns 0x1 at edge N+2.
- Write x0=0xDEADBEEF -> read-back response rsp_data=0x0; a later read of x0 returns 0x0.
- Write x3=0x3 and x9=0x1; hold rsp_ready=0 for 5 cycles on the read of x3 -> rsp_valid stays 1 and rsp_data stays 0x3; cmd_ready stays 0; a second cmd_valid is ignored.
- Dump after loading x1..x31 with 0x100+i, rsp_ready=1 -> 32 responses in address order 0..31 with data 0,0x101..0x11F; rsp_last only on addr 31; busy falls, then cmd_ready=1.
- Illegal op 11 with addr 7 -> single response rsp_err=1, rsp_data=0, rsp_addr=7, rsp_last=1; no rf_regwrite.
- Assert rst_n=0 during the WRITE cycle -> rf_regwrite drops asynchronously; the target register is unchanged; after release cmd_ready=1, rsp_valid=0, busy=0.
